// File: rtl/debouncer_pkg.sv
// Shared types and constants for the debouncer.
`timescale 1ns/1ps
package debouncer_pkg;

   typedef enum logic {STABLE, CHECKING} debouncer_state_t;

   localparam int GLITCH_COUNT_WIDTH = 8;

endpackage

// File: rtl/debouncer_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clock domain.
// Asynchronous active-low reset clears every stage.
`timescale 1ns/1ps
module synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic resetn,
   input  logic data_in,
   output logic data_out
);

   logic [STAGES-1:0] stages_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stages_q <= '0;
      end else begin
         stages_q[0] <= data_in;
         for (int i = 1; i < STAGES; i++) begin
            stages_q[i] <= stages_q[i-1];
         end
      end
   end

   assign data_out = stages_q[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debouncer: synchronizes data_in, accepts a new level only after it has held for
// DEBOUNCE_CYCLES cycles, and emits one-cycle edge strobes.
// Optional macro DEBOUNCER_GLITCH_COUNTER_EN adds a saturating glitch_count output.
`timescale 1ns/1ps
module debouncer
   import debouncer_pkg::*;
#(
   parameter int STAGES          = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic data_in,
   output logic data_out,
   output logic rising_edge,
   output logic falling_edge
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
   ,
   output logic [GLITCH_COUNT_WIDTH-1:0] glitch_count
`endif
);

   localparam int COUNTER_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                     syncData;
   debouncer_state_t         state_q, state_d;
   logic [COUNTER_WIDTH-1:0] count_q, count_d;
   logic                     dataOut_q, dataOut_d;
   logic                     risingEdge_q, risingEdge_d;
   logic                     fallingEdge_q, fallingEdge_d;
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
   logic                          glitchSeen;
   logic [GLITCH_COUNT_WIDTH-1:0] glitchCount_q, glitchCount_d;
`endif

   synchronizer #(
      .STAGES(STAGES)
   ) u_sync (
      .clock   (clock),
      .resetn  (~reset),
      .data_in (data_in),
      .data_out(syncData)
   );

   // A level change is only committed once syncData has disagreed with the
   // debounced output for DEBOUNCE_CYCLES consecutive samples.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      dataOut_d     = dataOut_q;
      risingEdge_d  = 1'b0;
      fallingEdge_d = 1'b0;
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
      glitchSeen    = 1'b0;
`endif
      unique case (state_q)
         STABLE: begin
            count_d = '0;
            if (syncData != dataOut_q) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  dataOut_d     = syncData;
                  risingEdge_d  = syncData;
                  fallingEdge_d = ~syncData;
               end else begin
                  state_d = CHECKING;
                  count_d = COUNTER_WIDTH'(1);
               end
            end
         end
         CHECKING: begin
            if (syncData == dataOut_q) begin
               state_d = STABLE;
               count_d = '0;
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
               glitchSeen = 1'b1;
`endif
            end else if (count_q == LAST_COUNT) begin
               state_d       = STABLE;
               count_d       = '0;
               dataOut_d     = syncData;
               risingEdge_d  = syncData;
               fallingEdge_d = ~syncData;
            end else begin
               count_d = count_q + COUNTER_WIDTH'(1);
            end
         end
      endcase
   end

`ifdef DEBOUNCER_GLITCH_COUNTER_EN
   always_comb begin
      glitchCount_d = glitchCount_q;
      if (glitchSeen && (glitchCount_q != '1)) begin
         glitchCount_d = glitchCount_q + GLITCH_COUNT_WIDTH'(1);
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= STABLE;
         count_q       <= '0;
         dataOut_q     <= 1'b0;
         risingEdge_q  <= 1'b0;
         fallingEdge_q <= 1'b0;
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
         glitchCount_q <= '0;
`endif
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         dataOut_q     <= dataOut_d;
         risingEdge_q  <= risingEdge_d;
         fallingEdge_q <= fallingEdge_d;
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
         glitchCount_q <= glitchCount_d;
`endif
      end
   end

   assign data_out     = dataOut_q;
   assign rising_edge  = risingEdge_q;
   assign falling_edge = fallingEdge_q;
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
   assign glitch_count = glitchCount_q;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock).
// Glitch-count checks are active when DEBOUNCER_GLITCH_COUNTER_EN is defined.
`timescale 1ns/1ps
module tb_debouncer;

   localparam int STAGES = 2;
   localparam int DC     = 4;

   logic clock    = 1'b0;
   logic reset    = 1'b1;
   logic data_in  = 1'b0;
   logic data_out;
   logic rising_edge;
   logic falling_edge;
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
   logic [7:0] glitch_count;
`endif

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 1'b0;

   debouncer #(
      .STAGES(STAGES),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .data_in     (data_in),
      .data_out    (data_out),
      .rising_edge (rising_edge),
      .falling_edge(falling_edge)
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
      ,
      .glitch_count(glitch_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: s is data_in delayed by STAGES edges; the output flips once the
   // last DC samples of s all disagree with it, and a glitch is a return to agreement
   // immediately after a disagreeing sample that did not cause a flip.
   bit syncQ[$];
   bit histQ[$];
   bit mOut   = 1'b0;
   bit mRise  = 1'b0;
   bit mFall  = 1'b0;
   int mGlitch = 0;

   always @(posedge clock or posedge reset) begin
      bit sNow;
      bit allDiffer;
      int n;
      if (reset) begin
         syncQ.delete();
         for (int i = 0; i < STAGES; i++) syncQ.push_back(1'b0);
         histQ.delete();
         mOut = 1'b0; mRise = 1'b0; mFall = 1'b0; mGlitch = 0;
      end else begin
         sNow = syncQ.pop_front();
         syncQ.push_back(data_in);
         histQ.push_back(sNow);
         if (histQ.size() > DC + 1) void'(histQ.pop_front());
         mRise = 1'b0;
         mFall = 1'b0;
         n = histQ.size();
         if (n >= 2 && sNow == mOut && histQ[n-2] != mOut) begin
            if (mGlitch < 255) mGlitch++;
         end else if (n >= DC) begin
            allDiffer = 1'b1;
            for (int i = n - DC; i < n; i++) if (histQ[i] == mOut) allDiffer = 1'b0;
            if (allDiffer) begin
               mOut  = ~mOut;
               mRise = mOut;
               mFall = ~mOut;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("model_data_out", data_out, mOut);
         checkOutput("model_rising", rising_edge, mRise);
         checkOutput("model_falling", falling_edge, mFall);
         checkOutput("strobes_exclusive", rising_edge & falling_edge, 0);
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
         checkOutput("model_glitch", glitch_count, mGlitch);
`endif
      end
   end

   // Holds a level for a number of cycles starting at 25% of a cycle; tallies strobes
   // and high cycles sampled 1 ns after each rising edge.
   task automatic applyStimulus(input bit level, input int cycles,
                                output int rises, output int falls, output int highs);
      rises = 0; falls = 0; highs = 0;
      data_in = level;
      repeat (cycles) begin
         @(posedge clock);
         #1;
         rises += int'(rising_edge);
         falls += int'(falling_edge);
         highs += int'(data_out);
      end
      #1.5;
   endtask

   task automatic expectRiseAfterRelease(input string name);
      for (int c = 1; c <= 7; c++) begin
         @(posedge clock);
         #1;
         checkOutput({name, "_out"}, data_out, (c >= 6) ? 1 : 0);
         checkOutput({name, "_rise"}, rising_edge, (c == 6) ? 1 : 0);
         checkOutput({name, "_fall"}, falling_edge, 0);
      end
      #1.5;
   endtask

   typedef struct {
      bit level;
      int cycles;
      bit expOut;
      int expRise;
      int expFall;
      int expHigh;
      int expGlitch;
   } vecRec_t;

   vecRec_t vectors[9];

   initial begin
      int rises, falls, highs, risePos;

      vectors[0] = '{1'b0, 10, 1'b0, 0, 0, 0, 0};
      vectors[1] = '{1'b1,  3, 1'b0, 0, 0, 0, 0};
      vectors[2] = '{1'b0, 10, 1'b0, 0, 0, 0, 1};
      vectors[3] = '{1'b1,  4, 1'b0, 0, 0, 0, 1};
      vectors[4] = '{1'b0, 12, 1'b0, 1, 1, 4, 1};
      vectors[5] = '{1'b1,  8, 1'b1, 1, 0, 3, 1};
      vectors[6] = '{1'b0,  2, 1'b1, 0, 0, 2, 1};
      vectors[7] = '{1'b1, 10, 1'b1, 0, 0, 10, 2};
      vectors[8] = '{1'b0, 10, 1'b0, 0, 1, 5, 2};

      // Reset held with data_in high: outputs stay low, then one rise after release.
      data_in = 1'b1;
      repeat (3) begin
         @(posedge clock);
         #1;
         checkOutput("reset_out", data_out, 0);
         checkOutput("reset_rise", rising_edge, 0);
         checkOutput("reset_fall", falling_edge, 0);
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
         checkOutput("reset_glitch", glitch_count, 0);
`endif
      end
      #1.5;
      reset = 1'b0;
      checkEn = 1'b1;
      expectRiseAfterRelease("release");

      // Table of level segments from a clean low state.
      reset = 1'b1;
      data_in = 1'b0;
      @(posedge clock);
      #2.5;
      reset = 1'b0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vectors[i].level, vectors[i].cycles, rises, falls, highs);
         checkOutput($sformatf("vec%0d_out", i), data_out, vectors[i].expOut);
         checkOutput($sformatf("vec%0d_rises", i), rises, vectors[i].expRise);
         checkOutput($sformatf("vec%0d_falls", i), falls, vectors[i].expFall);
         checkOutput($sformatf("vec%0d_highs", i), highs, vectors[i].expHigh);
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
         checkOutput($sformatf("vec%0d_glitch", i), glitch_count, vectors[i].expGlitch);
`endif
      end

      // Toggle every cycle, then hold high: a single rise six edges after the last change.
      for (int i = 0; i < 10; i++) begin
         data_in = (i % 2 == 0);
         @(posedge clock);
         #2.5;
      end
      data_in = 1'b1;
      rises = 0; risePos = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clock);
         #1;
         if (rising_edge) begin
            rises++;
            risePos = c;
         end
      end
      #1.5;
      checkOutput("toggle_rises", rises, 1);
      checkOutput("toggle_rise_pos", risePos, 6);
      checkOutput("toggle_out", data_out, 1);
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
      checkOutput("toggle_glitch", glitch_count, 7);

      // Many rejected low pulses drive the glitch counter into saturation.
      for (int i = 0; i < 300; i++) begin
         data_in = 1'b0;
         @(posedge clock);
         #2.5;
         data_in = 1'b1;
         repeat (2) begin
            @(posedge clock);
            #2.5;
         end
      end
      repeat (4) @(posedge clock);
      #2.5;
      checkOutput("glitch_saturated", glitch_count, 255);
      checkOutput("glitch_sat_out", data_out, 1);
`endif

      // Reset asserted while checking a fall with the counter at 2.
      data_in = 1'b0;
      repeat (4) @(posedge clock);
      #7;
      reset = 1'b1;
      data_in = 1'b1;
      #1;
      checkOutput("midcheck_out", data_out, 0);
      checkOutput("midcheck_rise", rising_edge, 0);
      checkOutput("midcheck_fall", falling_edge, 0);
`ifdef DEBOUNCER_GLITCH_COUNTER_EN
      checkOutput("midcheck_glitch", glitch_count, 0);
`endif
      @(posedge clock);
      #2.5;
      reset = 1'b0;
      expectRiseAfterRelease("midcheck_release");

      // Random level runs cross-checked against the reference model every cycle.
      for (int r = 0; r < 200; r++) begin
         data_in = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 8)) begin
            @(posedge clock);
            #2.5;
         end
      end
      repeat (10) @(posedge clock);
      #2.5;
      checkEn = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
